// File: rtl/mmu_pkg.sv
// Shared address map, IRQ bit indices, OAM DMA state type and address helpers
// for the mmu block.
package mmu_pkg;

  localparam logic [15:0] IF_ADDR       = 16'hFF0F;
  localparam logic [15:0] DMA_ADDR      = 16'hFF46;
  localparam logic [15:0] BOOTLOCK_ADDR = 16'hFF50;
  localparam logic [15:0] IE_ADDR       = 16'hFFFF;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [7:0]  OAM_LEN       = 8'd160;
  localparam logic [15:0] ECHO_BASE     = 16'hE000;
  localparam logic [15:0] ECHO_END      = 16'hFDFF;
  localparam logic [15:0] ECHO_OFFSET   = 16'h2000;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2
  } dma_state_t;

  // Echo RAM E000-FDFF mirrors C000-DDFF.
  function automatic logic [15:0] echo_remap(input logic [15:0] addr);
    if (addr >= ECHO_BASE && addr <= ECHO_END) begin
      return addr - ECHO_OFFSET;
    end
    return addr;
  endfunction

  function automatic logic is_internal(input logic [15:0] addr);
    return (addr == IF_ADDR) || (addr == DMA_ADDR) ||
           (addr == BOOTLOCK_ADDR) || (addr == IE_ADDR);
  endfunction

endpackage

// File: rtl/mmu_oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src,8'h00} to FE00, alternating a
// read cycle and a write cycle per byte. Built only when GB_OAM_DMA_EN is set.
module oam_dma
  import mmu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_src,
  input  logic [7:0]  i_rd_data,
  output logic        o_active,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data_w,
  output logic        o_do_write,
  output dma_state_t  o_state
);

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic [7:0] r_idx;
  logic [7:0] w_next_idx;
  logic [7:0] r_src;
  logic [7:0] r_data;
  logic       w_last;

  assign w_last = (r_idx == (OAM_LEN - 8'd1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= DMA_IDLE;
      r_idx   <= 8'd0;
      r_src   <= 8'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (i_start) begin
        r_src <= i_src;
      end
      if (r_state == DMA_READ && !i_start) begin
        r_data <= i_rd_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    o_active     = 1'b0;
    o_do_write   = 1'b0;
    o_addr       = OAM_BASE;
    case (r_state)
      DMA_IDLE: begin
      end
      DMA_READ: begin
        o_active     = 1'b1;
        o_addr       = {r_src, r_idx};
        w_next_state = DMA_WRITE;
      end
      DMA_WRITE: begin
        o_active   = 1'b1;
        o_do_write = 1'b1;
        o_addr     = OAM_BASE + {8'h00, r_idx};
        if (w_last) begin
          w_next_state = DMA_IDLE;
          w_next_idx   = 8'd0;
        end else begin
          w_next_state = DMA_READ;
          w_next_idx   = r_idx + 8'd1;
        end
      end
      default: begin
        w_next_state = DMA_IDLE;
      end
    endcase
    // A new FF46 write restarts from byte 0 regardless of progress.
    if (i_start) begin
      w_next_state = DMA_READ;
      w_next_idx   = 8'd0;
    end
  end

  assign o_data_w = r_data;
  assign o_state  = r_state;

endmodule

// File: rtl/mmu.sv
// Game Boy memory-management / bus-control block: echo remap, N-slave read
// priority mux, boot-ROM lock, IE/IF interrupt registers and optional OAM DMA
// (enabled by defining GB_OAM_DMA_EN).
module mmu
  import mmu_pkg::*;
#(
  parameter int NUM_SLAVES = 5,
  parameter int NUM_IRQ    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_data_w,
  input  logic                    cpu_do_write,
  output logic [7:0]              cpu_data_r,
  output logic [15:0]             bus_addr,
  output logic [7:0]              bus_data_w,
  output logic                    bus_do_write,
  input  logic [8*NUM_SLAVES-1:0] slave_data_r,
  input  logic [NUM_SLAVES-1:0]   slave_active,
  output logic                    bootrom_enabled,
  input  logic [NUM_IRQ-1:0]      irq_req,
  input  logic                    irq_ack,
  input  logic [2:0]              irq_ack_idx,
  output logic [NUM_IRQ-1:0]      irq_pending,
  output logic                    irq_any,
  output logic                    dma_active
);

  logic [7:0]         r_ie;
  logic [7:0]         r_dma_reg;
  logic [NUM_IRQ-1:0] r_if;
  logic               r_bootrom_enabled;

  logic [NUM_IRQ-1:0] w_if_next;
  logic [7:0]         w_if_rd;
  logic               w_cpu_internal;
  logic [7:0]         w_slave_data;
  logic [15:0]        w_bus_addr_raw;

  logic               w_dma_active;
  logic [15:0]        w_dma_addr;
  logic [7:0]         w_dma_data_w;
  logic               w_dma_do_write;

  assign w_cpu_internal = is_internal(cpu_addr);

`ifdef GB_OAM_DMA_EN
  logic       w_dma_start;
  dma_state_t w_dma_state;

  assign w_dma_start = cpu_do_write && (cpu_addr == DMA_ADDR);

  oam_dma u_oam_dma (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (w_dma_start),
    .i_src      (cpu_data_w),
    .i_rd_data  (w_slave_data),
    .o_active   (w_dma_active),
    .o_addr     (w_dma_addr),
    .o_data_w   (w_dma_data_w),
    .o_do_write (w_dma_do_write),
    .o_state    (w_dma_state)
  );
`else
  assign w_dma_active   = 1'b0;
  assign w_dma_addr     = 16'h0000;
  assign w_dma_data_w   = 8'h00;
  assign w_dma_do_write = 1'b0;
`endif

  // Lowest-indexed active slave wins; scanning downward lets it overwrite.
  always_comb begin
    w_slave_data = 8'hFF;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (slave_active[k]) begin
        w_slave_data = slave_data_r[8*k +: 8];
      end
    end
  end

  // Order matters: CPU write, then acknowledge, then requests OR'ed last.
  always_comb begin
    w_if_next = r_if;
    if (cpu_do_write && cpu_addr == IF_ADDR) begin
      w_if_next = cpu_data_w[NUM_IRQ-1:0];
    end
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (irq_ack && irq_ack_idx == 3'(n)) begin
        w_if_next[n] = 1'b0;
      end
    end
    w_if_next = w_if_next | irq_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie              <= 8'h00;
      r_dma_reg         <= 8'h00;
      r_if              <= '0;
      r_bootrom_enabled <= 1'b1;
    end else begin
      r_if <= w_if_next;
      if (cpu_do_write) begin
        case (cpu_addr)
          IE_ADDR:  r_ie      <= cpu_data_w;
          DMA_ADDR: r_dma_reg <= cpu_data_w;
          BOOTLOCK_ADDR: begin
            if (cpu_data_w != 8'h00) begin
              r_bootrom_enabled <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    w_if_rd              = 8'hFF;
    w_if_rd[NUM_IRQ-1:0] = r_if;
  end

  always_comb begin
    case (cpu_addr)
      IF_ADDR:       cpu_data_r = w_if_rd;
      IE_ADDR:       cpu_data_r = r_ie;
      DMA_ADDR:      cpu_data_r = r_dma_reg;
      BOOTLOCK_ADDR: cpu_data_r = {7'h7F, ~r_bootrom_enabled};
      default:       cpu_data_r = w_dma_active ? 8'hFF : w_slave_data;
    endcase
  end

  // Strobe is masked during reset so an in-flight DMA write is cut off at once.
  assign w_bus_addr_raw = w_dma_active ? w_dma_addr : cpu_addr;
  assign bus_addr       = echo_remap(w_bus_addr_raw);
  assign bus_data_w     = w_dma_active ? w_dma_data_w : cpu_data_w;
  assign bus_do_write   = ~reset & (w_dma_active ? w_dma_do_write
                                                 : (cpu_do_write & ~w_cpu_internal));

  assign bootrom_enabled = r_bootrom_enabled;
  assign irq_pending     = r_ie[NUM_IRQ-1:0] & r_if;
  assign irq_any         = |irq_pending;
  assign dma_active      = w_dma_active;

endmodule

// File: tb/tb_mmu.sv
// Self-checking bench for mmu: cycle-by-cycle reference model plus directed
// vectors; DMA vectors are active when GB_OAM_DMA_EN is defined.
module tb_mmu;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_do_write;
  logic [7:0]  cpu_data_r;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_w;
  logic        bus_do_write;
  logic [39:0] slave_data_r;
  logic [4:0]  slave_active;
  logic        bootrom_enabled;
  logic [4:0]  irq_req;
  logic        irq_ack;
  logic [2:0]  irq_ack_idx;
  logic [4:0]  irq_pending;
  logic        irq_any;
  logic        dma_active;

  mmu #(.NUM_SLAVES(5), .NUM_IRQ(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .cpu_data_w      (cpu_data_w),
    .cpu_do_write    (cpu_do_write),
    .cpu_data_r      (cpu_data_r),
    .bus_addr        (bus_addr),
    .bus_data_w      (bus_data_w),
    .bus_do_write    (bus_do_write),
    .slave_data_r    (slave_data_r),
    .slave_active    (slave_active),
    .bootrom_enabled (bootrom_enabled),
    .irq_req         (irq_req),
    .irq_ack         (irq_ack),
    .irq_ack_idx     (irq_ack_idx),
    .irq_pending     (irq_pending),
    .irq_any         (irq_any),
    .dma_active      (dma_active)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- slave environment ----------------
  logic        env_auto;
  logic [4:0]  man_active;
  logic [39:0] man_data;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign slave_active = env_auto ? 5'b00001 : man_active;
  assign slave_data_r = env_auto ? {32'h0, mem_f(bus_addr)} : man_data;

  // ---------------- counters / check ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic       m_boot;
  logic [7:0] m_ie;
  logic [4:0] m_if;
  logic [7:0] m_dma_reg;
  logic       m_dma_on;
  int         m_cnt;
  logic [15:0] m_base;
  logic       check_en;

  function automatic logic [15:0] remap_m(input logic [15:0] a);
    return (a >= 16'hE000 && a <= 16'hFDFF) ? a - 16'h2000 : a;
  endfunction

  function automatic logic internal_m(input logic [15:0] a);
    return a == 16'hFF0F || a == 16'hFF46 || a == 16'hFF50 || a == 16'hFFFF;
  endfunction

  function automatic logic [7:0] prio_m(input logic [4:0] act, input logic [39:0] data);
    for (int k = 0; k < 5; k++) if (act[k]) return data[8*k +: 8];
    return 8'hFF;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_boot = 1'b1; m_ie = 8'h00; m_if = 5'h00; m_dma_reg = 8'h00;
      m_dma_on = 1'b0; m_cnt = 0; m_base = 16'h0000;
    end else begin
      if (m_dma_on) begin
        if (m_cnt == 319) m_dma_on = 1'b0;
        else m_cnt++;
      end
      if (cpu_do_write) begin
        if (cpu_addr == 16'hFF0F) m_if = cpu_data_w[4:0];
        if (cpu_addr == 16'hFFFF) m_ie = cpu_data_w;
        if (cpu_addr == 16'hFF50 && cpu_data_w != 8'h00) m_boot = 1'b0;
        if (cpu_addr == 16'hFF46) begin
          m_dma_reg = cpu_data_w;
`ifdef GB_OAM_DMA_EN
          m_dma_on = 1'b1; m_cnt = 0; m_base = {cpu_data_w, 8'h00};
`endif
        end
      end
      if (irq_ack && irq_ack_idx < 3'd5) m_if[irq_ack_idx] = 1'b0;
      m_if = m_if | irq_req;
    end
  end

  // ---------------- compare process + scoreboard ----------------
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic [7:0]  e_rd;
    logic [23:0] got;
    if (check_en && !reset) begin
      if (m_dma_on) begin
        e_addr = (m_cnt % 2 == 0) ? remap_m(m_base + 16'(m_cnt / 2)) : 16'hFE00 + 16'(m_cnt / 2);
        e_we   = (m_cnt % 2 == 1);
        e_wd   = mem_f(remap_m(m_base + 16'(m_cnt / 2)));
      end else begin
        e_addr = remap_m(cpu_addr);
        e_we   = cpu_do_write && !internal_m(cpu_addr);
        e_wd   = cpu_data_w;
      end
      case (cpu_addr)
        16'hFF0F: e_rd = {3'b111, m_if};
        16'hFFFF: e_rd = m_ie;
        16'hFF46: e_rd = m_dma_reg;
        16'hFF50: e_rd = {7'h7F, ~m_boot};
        default:  e_rd = m_dma_on ? 8'hFF : (env_auto ? mem_f(e_addr) : prio_m(man_active, man_data));
      endcase
      chk("cyc bus_addr", bus_addr, e_addr);
      chk("cyc bus_do_write", bus_do_write, e_we);
      chk("cyc cpu_data_r", cpu_data_r, e_rd);
      chk("cyc bootrom_enabled", bootrom_enabled, m_boot);
      chk("cyc irq_pending", irq_pending, m_ie[4:0] & m_if);
      chk("cyc irq_any", irq_any, |(m_ie[4:0] & m_if));
      chk("cyc dma_active", dma_active, m_dma_on);
      if (e_we) exp_q.push_back({e_addr, e_wd});
      if (bus_do_write) begin
        if (exp_q.size() == 0) chk("sb unexpected write", {bus_addr, bus_data_w}, 24'hxxxxxx);
        else begin
          got = {bus_addr, bus_data_w};
          chk("sb write", got, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_w = d; cpu_do_write = 1'b1;
    tick();
    cpu_do_write = 1'b0;
  endtask

  task automatic rd_check(input logic [15:0] a, input logic [7:0] e, input string name);
    cpu_addr = a;
    @(negedge clk);
    chk(name, cpu_data_r, e);
    tick();
  endtask

  task automatic bus_check(input logic [15:0] a, input logic [15:0] e, input string name);
    cpu_addr = a;
    @(negedge clk);
    chk(name, bus_addr, e);
    tick();
  endtask

  task automatic wait_dma_idle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!dma_active) done = 1'b1;
    end
    chk(name, done, 1'b1);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int act_cnt;
    int wr_cnt;
    logic done;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_data_w = 8'h00; cpu_do_write = 1'b0;
    irq_req = 5'h00; irq_ack = 1'b0; irq_ack_idx = 3'd0;
    env_auto = 1'b1; man_active = 5'h00; man_data = 40'h0; check_en = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; check_en = 1'b1;

    @(negedge clk);
    chk("rst bootrom_enabled", bootrom_enabled, 1'b1);
    chk("rst dma_active", dma_active, 1'b0);
    chk("rst irq_pending", irq_pending, 5'h00);
    chk("rst irq_any", irq_any, 1'b0);
    chk("rst bus_do_write", bus_do_write, 1'b0);
    tick();
    rd_check(16'hFF0F, 8'hE0, "rst IF read");
    rd_check(16'hFFFF, 8'h00, "rst IE read");
    rd_check(16'hFF46, 8'h00, "rst FF46 read");
    rd_check(16'hFF50, 8'hFE, "rst FF50 read");

    // read priority
    env_auto = 1'b0; man_active = 5'b00110;
    man_data = {8'h44, 8'h33, 8'h22, 8'h11, 8'h5C};
    rd_check(16'hC000, 8'h11, "prio slave1 over slave2");
    man_active = 5'b10001;
    rd_check(16'hC000, 8'h5C, "prio slave0 over slave4");
    man_active = 5'b00000;
    rd_check(16'hC000, 8'hFF, "prio none active");
    env_auto = 1'b1;

    // echo remap
    bus_check(16'hE123, 16'hC123, "echo E123");
    bus_check(16'hFE00, 16'hFE00, "echo FE00 passthru");
    bus_check(16'hE000, 16'hC000, "echo low edge");
    bus_check(16'hFDFF, 16'hDDFF, "echo high edge");
    bus_check(16'hDFFF, 16'hDFFF, "echo below range");

    // boot ROM lock
    cpu_write(16'hFF50, 8'h00);
    @(negedge clk); chk("boot stays after 0", bootrom_enabled, 1'b1); tick();
    cpu_write(16'hFF50, 8'h01);
    @(negedge clk); chk("boot clears", bootrom_enabled, 1'b0); tick();
    cpu_write(16'hFF50, 8'h00);
    @(negedge clk); chk("boot sticky", bootrom_enabled, 1'b0); tick();
    rd_check(16'hFF50, 8'hFF, "FF50 locked read");

    // IE / IF arbitration
    cpu_addr = 16'hFFFF; cpu_data_w = 8'h05; cpu_do_write = 1'b1;
    @(negedge clk); chk("IE write not forwarded", bus_do_write, 1'b0);
    tick(); cpu_do_write = 1'b0;
    irq_req = 5'b00100; tick(); irq_req = 5'h00;
    @(negedge clk);
    chk("irq_pending timer", irq_pending, 5'h04);
    chk("irq_any timer", irq_any, 1'b1);
    tick();
    rd_check(16'hFF0F, 8'hE4, "IF read E4");
    irq_ack = 1'b1; irq_ack_idx = 3'd2; irq_req = 5'b00100; tick();
    irq_ack = 1'b0; irq_req = 5'h00;
    rd_check(16'hFF0F, 8'hE4, "req beats ack");
    irq_ack = 1'b1; irq_ack_idx = 3'd2; tick(); irq_ack = 1'b0;
    rd_check(16'hFF0F, 8'hE0, "ack clears bit2");
    irq_req = 5'b00001; tick(); irq_req = 5'h00;
    irq_ack = 1'b1; irq_ack_idx = 3'd7; tick(); irq_ack = 1'b0;
    @(negedge clk); chk("ack idx7 ignored pending", irq_pending, 5'h01); tick();
    rd_check(16'hFF0F, 8'hE1, "ack idx7 ignored IF");
    cpu_write(16'hFF0F, 8'h00);
    @(negedge clk); chk("IF write clears any", irq_any, 1'b0); tick();
    irq_req = 5'b00010; cpu_write(16'hFF0F, 8'h00); irq_req = 5'h00;
    rd_check(16'hFF0F, 8'hE2, "req beats write");
    irq_ack = 1'b1; irq_ack_idx = 3'd4; cpu_write(16'hFF0F, 8'h1F); irq_ack = 1'b0;
    rd_check(16'hFF0F, 8'hEF, "ack after write");
    cpu_write(16'hFF0F, 8'h00);

    // slave writes forwarded with remap
    cpu_addr = 16'hE010; cpu_data_w = 8'hA5; cpu_do_write = 1'b1;
    @(negedge clk);
    chk("slave write strobe", bus_do_write, 1'b1);
    chk("slave write addr", bus_addr, 16'hC010);
    chk("slave write data", bus_data_w, 8'hA5);
    tick(); cpu_do_write = 1'b0;

`ifndef GB_OAM_DMA_EN
    cpu_addr = 16'hFF46; cpu_data_w = 8'h37; cpu_do_write = 1'b1;
    @(negedge clk); chk("FF46 not forwarded", bus_do_write, 1'b0);
    tick(); cpu_do_write = 1'b0;
    @(negedge clk); chk("no dma without engine", dma_active, 1'b0); tick();
    rd_check(16'hFF46, 8'h37, "FF46 latch read");
`else
    // full copy from C100
    cpu_write(16'hFF46, 8'hC1);
    cpu_addr = 16'hC000;
    act_cnt = 0; wr_cnt = 0; done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!dma_active) done = 1'b1;
      else begin
        act_cnt++;
        if (act_cnt == 100) chk("dma cpu read C000", cpu_data_r, 8'hFF);
        if (bus_do_write) begin
          wr_cnt++;
          if (wr_cnt == 1) begin
            chk("dma first addr", bus_addr, 16'hFE00);
            chk("dma first data", bus_data_w, 8'h9B);
          end
          if (wr_cnt == 160) begin
            chk("dma last addr", bus_addr, 16'hFE9F);
            chk("dma last data", bus_data_w, 8'h04);
          end
        end
      end
    end
    chk("dma copy finished", done, 1'b1);
    chk("dma active cycles", act_cnt, 320);
    chk("dma write strobes", wr_cnt, 160);
    tick();
    rd_check(16'hFF46, 8'hC1, "FF46 latch read");

    // restart at byte 50 with echo source
    cpu_write(16'hFF46, 8'hC3);
    repeat (100) tick();
    cpu_write(16'hFF46, 8'hE2);
    @(negedge clk);
    chk("restart read addr", bus_addr, 16'hC200);
    chk("restart active", dma_active, 1'b1);
    tick();
    wait_dma_idle("restart finished");
    rd_check(16'hFF46, 8'hE2, "FF46 after restart");

    // reset mid-transfer
    cpu_write(16'hFF46, 8'hC1);
    repeat (31) tick();
    reset = 1'b1;
    @(negedge clk); chk("reset cycle no write", bus_do_write, 1'b0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("reset aborts dma", dma_active, 1'b0);
    chk("reset no strobe", bus_do_write, 1'b0);
    chk("reset boot re-enabled", bootrom_enabled, 1'b1);
    tick();
`endif

    repeat (2) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
